elevator_dispatcher: RTL

Two-car hall-call dispatcher for the 5-floor elevator system.
- Latches up/down hall-call buttons.
- Scans pending unassigned calls round-robin and picks the cheaper car for each, using distance plus a direction penalty.
- Offers the call to that car's controller over a valid/ready channel.
- Clears the call when the owning car reports arrival at that floor.
- Sits between the hall button panel and the per-car controllers.

---
 rtl/elevator_pkg.sv | 26 ++
 rtl/elevator_call_cost.sv | 22 ++
 rtl/elevator_dispatcher.sv | 132 +++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor encodings, dispatcher states and call-index helpers
package elevator_pkg;
  localparam int NUM_FLOORS = 5;
  localparam int FLOOR_W = 3;
  localparam int NUM_CALLS = 2 * NUM_FLOORS;
  localparam logic [3:0] WRONG_DIR_PENALTY = 4'd4;
  localparam logic [FLOOR_W-1:0] FLOOR_1 = 3'b001;
  localparam logic [FLOOR_W-1:0] FLOOR_2 = 3'b010;
  localparam logic [FLOOR_W-1:0] FLOOR_3 = 3'b011;
  localparam logic [FLOOR_W-1:0] FLOOR_4 = 3'b100;
  localparam logic [FLOOR_W-1:0] FLOOR_5 = 3'b101;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  typedef enum logic [1:0] {IDLE, SCAN, OFFER} disp_state_t;
  function automatic logic [FLOOR_W-1:0] call_floor(input logic [3:0] idx);
    logic [3:0] f;
    f = idx < 4'(NUM_FLOORS) ? idx + 4'd1 : idx - 4'd4;
    return f[FLOOR_W-1:0];
  endfunction
  // Up and down call bits for one floor; out-of-range floors select nothing
  function automatic logic [NUM_CALLS-1:0] floor_mask(input logic [FLOOR_W-1:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = 5'd1 << (f - 3'd1);
    return {m, m};
  endfunction
endpackage

// File: rtl/elevator_call_cost.sv
// elevator_call_cost: distance plus wrong-direction penalty for one car
module elevator_call_cost
  import elevator_pkg::*;
#(
  parameter logic [3:0] PENALTY = WRONG_DIR_PENALTY
) (
  input  logic [FLOOR_W-1:0] i_car_floor,
  input  logic               i_move,
  input  logic               i_dir,
  input  logic [FLOOR_W-1:0] i_call_floor,
  output logic [3:0]         o_cost
);
  logic               w_below;
  logic               w_above;
  logic               w_wrong;
  logic [FLOOR_W-1:0] w_dist;
  assign w_below = i_call_floor < i_car_floor;
  assign w_above = i_call_floor > i_car_floor;
  assign w_dist  = w_below ? i_car_floor - i_call_floor : i_call_floor - i_car_floor;
  assign w_wrong = i_move & (((i_dir == DIR_UP) & w_below) | ((i_dir == DIR_DOWN) & w_above));
  assign o_cost  = {1'b0, w_dist} + (w_wrong ? PENALTY : 4'd0);
endmodule

// File: rtl/elevator_dispatcher.sv
// elevator_dispatcher: latches hall calls and offers each to the cheaper of two cars
module elevator_dispatcher
  import elevator_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] i_hall_up,
  input  logic [NUM_FLOORS-1:0] i_hall_down,
  input  logic [FLOOR_W-1:0]    i_car0_floor,
  input  logic                  i_car0_move,
  input  logic                  i_car0_dir,
  input  logic                  i_car0_arrive,
  input  logic [FLOOR_W-1:0]    i_car1_floor,
  input  logic                  i_car1_move,
  input  logic                  i_car1_dir,
  input  logic                  i_car1_arrive,
  output logic                  o_car0_req_valid,
  output logic [FLOOR_W-1:0]    o_car0_req_floor,
  output logic                  o_car0_req_up,
  input  logic                  i_car0_req_ready,
  output logic                  o_car1_req_valid,
  output logic [FLOOR_W-1:0]    o_car1_req_floor,
  output logic                  o_car1_req_up,
  input  logic                  i_car1_req_ready,
  output logic [NUM_FLOORS-1:0] o_pending_up,
  output logic [NUM_FLOORS-1:0] o_pending_down,
  output logic                  o_busy
);
  logic [NUM_CALLS-1:0] r_pend;
  logic [NUM_CALLS-1:0] r_ov;
  logic [NUM_CALLS-1:0] r_owner;
  logic [3:0]           r_ptr;
  disp_state_t          r_state;
  logic                 r_v0;
  logic                 r_v1;
  logic                 r_target;
  logic                 r_up;
  logic                 r_busy;
  logic [FLOOR_W-1:0]   r_floor;
  logic [NUM_CALLS-1:0] w_set;
  logic [NUM_CALLS-1:0] w_clr;
  logic [NUM_CALLS-1:0] w_pend_nx;
  logic [NUM_CALLS-1:0] w_ov_nx;
  logic [FLOOR_W-1:0]   w_call_floor;
  logic [3:0]           w_cost0;
  logic [3:0]           w_cost1;
  logic [3:0]           w_ptr_nx;
  logic                 w_pick1;
  logic                 w_accept;
  logic                 w_free;
  // Top up-call and bottom down-call have no button, so they are masked off
  assign w_set = {i_hall_down & 5'b11110, i_hall_up & 5'b01111};
  assign w_clr = (floor_mask(i_car0_floor) & r_ov & ~r_owner & {NUM_CALLS{i_car0_arrive}})
               | (floor_mask(i_car1_floor) & r_ov & r_owner & {NUM_CALLS{i_car1_arrive}});
  assign w_accept     = (r_state == OFFER) & (r_target ? i_car1_req_ready : i_car0_req_ready);
  assign w_pend_nx    = (r_pend & ~w_clr) | w_set;
  assign w_ov_nx      = (r_ov & ~w_clr) | (w_accept ? 10'b1 << r_ptr : 10'b0);
  assign w_free       = r_pend[r_ptr] & ~r_ov[r_ptr];
  assign w_call_floor = call_floor(r_ptr);
  assign w_ptr_nx     = r_ptr == 4'(NUM_CALLS - 1) ? 4'd0 : r_ptr + 4'd1;
  assign w_pick1      = w_cost1 < w_cost0;
  elevator_call_cost u_cost0 (
    .i_car_floor (i_car0_floor),
    .i_move      (i_car0_move),
    .i_dir       (i_car0_dir),
    .i_call_floor(w_call_floor),
    .o_cost      (w_cost0)
  );
  elevator_call_cost u_cost1 (
    .i_car_floor (i_car1_floor),
    .i_move      (i_car1_move),
    .i_dir       (i_car1_dir),
    .i_call_floor(w_call_floor),
    .o_cost      (w_cost1)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pend   <= '0;
      r_ov     <= '0;
      r_owner  <= '0;
      r_ptr    <= '0;
      r_state  <= IDLE;
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_target <= 1'b0;
      r_up     <= 1'b0;
      r_busy   <= 1'b0;
      r_floor  <= FLOOR_1;
    end else begin
      r_pend <= w_pend_nx;
      r_ov   <= w_ov_nx;
      r_busy <= |(w_pend_nx & ~w_ov_nx);
      if (w_accept) r_owner[r_ptr] <= r_target;
      case (r_state)
        IDLE: if (r_busy) r_state <= SCAN;
        SCAN: begin
          if (!r_busy) r_state <= IDLE;
          else if (w_free) begin
            r_target <= w_pick1;
            r_floor  <= w_call_floor;
            r_up     <= r_ptr < 4'(NUM_FLOORS);
            r_v0     <= !w_pick1;
            r_v1     <= w_pick1;
            r_state  <= OFFER;
          end else r_ptr <= w_ptr_nx;
        end
        OFFER: begin
          if (w_accept) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_ptr   <= w_ptr_nx;
            r_state <= SCAN;
          end else if (!w_free) begin
            r_v0    <= 1'b0;
            r_v1    <= 1'b0;
            r_state <= SCAN;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign o_car0_req_valid = r_v0;
  assign o_car1_req_valid = r_v1;
  assign o_car0_req_floor = r_floor;
  assign o_car1_req_floor = r_floor;
  assign o_car0_req_up    = r_up;
  assign o_car1_req_up    = r_up;
  assign o_pending_up     = r_pend[NUM_FLOORS-1:0];
  assign o_pending_down   = r_pend[NUM_CALLS-1:NUM_FLOORS];
  assign o_busy           = r_busy;
endmodule
